// File: rtl/hazard_sched.sv
// hazard_sched -- pipeline hazard scheduler for the 5-stage MIPS core.
//
// This block sits beside the ID stage. It drives the enables for the
// IF/ID and ID/EX pipeline registers. It handles three cases:
//   - load-use hazards: insert a single bubble,
//   - taken branches: flush the wrong-path instructions,
//   - data memory busy: freeze the whole pipe.
// It also keeps saturating stall and flush counters for performance debug.
//
// Parameters
//   FLUSH_CYCLES : flush cycles per taken branch (>= 1)
//   CNT_W        : width of the performance counters
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-low reset
//   id_rs/id_rt  : source register fields of the instruction in ID
//   id_use_rs/rt : the ID instruction actually reads Rs / Rt
//   ex_memread   : the instruction in EX is a load
//   ex_rt        : destination register of that load
//   branch_taken : single-cycle pulse, EX resolved a taken branch
//   mem_busy     : data memory not ready, the pipe must hold
//   pc_write     : PC register enable
//   ifid_write   : IF/ID register enable
//   ifid_flush   : clear IF/ID to a NOP
//   idex_bubble  : zero the ID/EX control signals (hazard_detected)
//   pipe_freeze  : hold the ID/EX, EX/MEM and MEM/WB registers
//   stall_cnt    : saturating count of cycles with pc_write = 0
//   flush_cnt    : saturating count of cycles with ifid_flush = 1
module hazard_sched #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_freeze,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned FR_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FR_W-1:0] FLUSH_LOAD = FR_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FREEZE = 2'd1,
      FLUSH  = 2'd2
   } state_t;

   state_t          state, state_n;
   logic            br_pend, br_pend_n;
   logic [FR_W-1:0] flush_rem, flush_rem_n;
   logic            lu;

   // $0 is hardwired to zero, so a load targeting it can never create a hazard.
   assign lu = ex_memread && (ex_rt != 5'd0) &&
               (((ex_rt == id_rs) && id_use_rs) ||
                ((ex_rt == id_rt) && id_use_rt));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         br_pend   <= 1'b0;
         flush_rem <= '0;
      end else begin
         state     <= state_n;
         br_pend   <= br_pend_n;
         flush_rem <= flush_rem_n;
      end
   end

   always_comb begin
      state_n     = state;
      br_pend_n   = br_pend;
      flush_rem_n = flush_rem;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;

      if (!rst) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_n     = RUN;
         br_pend_n   = 1'b0;
         flush_rem_n = '0;
      end else if (mem_busy) begin
         // Hold everything. A branch resolved now is remembered and is
         // executed on the first cycle after memory is ready again.
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         pipe_freeze = 1'b1;
         state_n     = FREEZE;
         if (branch_taken) br_pend_n = 1'b1;
      end else if (branch_taken || br_pend) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         br_pend_n   = 1'b0;
         flush_rem_n = FLUSH_LOAD;
         state_n     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if ((state == FLUSH) ||
                   ((state == FREEZE) && (flush_rem != '0))) begin
         // A non-zero flush_rem in FREEZE means a freeze interrupted a
         // flush. The flush resumes immediately on the cycle mem_busy falls.
         // The branch cycle itself was flush cycle 1, so flush_rem counts
         // only the cycles that remain.
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         flush_rem_n = flush_rem - FR_W'(1);
         state_n     = (flush_rem == FR_W'(1)) ? RUN : FLUSH;
      end else begin
         state_n = RUN;
         if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule
